// File: rtl/gpr_file_p_if.sv
// Bus bundle for gpr_file_p: two read ports, one write port, clear request and status.
// The master drives addresses and writes; the slave (register file) returns data and status.
interface gpr_file_p_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] R_Addr_A;
  logic [ADDR_W-1:0] R_Addr_B;
  logic [DATA_W-1:0] R_Data_A;
  logic [DATA_W-1:0] R_Data_B;
  logic              Write_Reg;
  logic [ADDR_W-1:0] W_Addr;
  logic [DATA_W-1:0] W_Data;
  logic              Clr_Req;
  logic              Busy;
  logic              Wr_Drop;

  modport master (
    output R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data, Clr_Req,
    input  R_Data_A, R_Data_B, Busy, Wr_Drop
  );

  modport slave (
    input  R_Addr_A, R_Addr_B, Write_Reg, W_Addr, W_Data, Clr_Req,
    output R_Data_A, R_Data_B, Busy, Wr_Drop
  );
endinterface

// File: rtl/gpr_file_p.sv
// Parametrised GPR file with optional zero register, write-to-read bypass and a
// one-entry-per-cycle clear engine so the array can map onto RAM primitives.
module gpr_file_p #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input logic         clk,
  input logic         rst,
  gpr_file_p_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              wr_drop;
  logic [DATA_W-1:0] regs [DEPTH];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      wr_drop <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + 1'b1;
          wr_drop <= bus.Write_Reg;
          if (clr_cnt == {ADDR_W{1'b1}}) state <= IDLE;
        end
        IDLE: begin
          wr_drop <= 1'b0;
          if (bus.Clr_Req) begin
            state   <= CLEAR;
            clr_cnt <= '0;
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Single array write port shared by the clear engine and the normal write path.
  always_comb begin
    mem_we   = 1'b0;
    mem_addr = bus.W_Addr;
    mem_data = bus.W_Data;
    if (rst) begin
      if (state == CLEAR) begin
        mem_we   = 1'b1;
        mem_addr = clr_cnt;
        mem_data = '0;
      end else if (bus.Write_Reg && !(ZERO_REG != 0 && bus.W_Addr == '0)) begin
        mem_we = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) regs[mem_addr] <= mem_data;
  end

  function automatic logic [DATA_W-1:0] read_sel(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] stored,
    input logic              busy,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata
  );
    if (busy)                                  return '0;
    if (ZERO_REG != 0 && addr == '0)           return '0;
    if (BYPASS != 0 && we && waddr == addr)    return wdata;
    return stored;
  endfunction

  assign bus.Busy     = (state == CLEAR);
  assign bus.Wr_Drop  = wr_drop;
  assign bus.R_Data_A = read_sel(bus.R_Addr_A, regs[bus.R_Addr_A], bus.Busy,
                                 bus.Write_Reg, bus.W_Addr, bus.W_Data);
  assign bus.R_Data_B = read_sel(bus.R_Addr_B, regs[bus.R_Addr_B], bus.Busy,
                                 bus.Write_Reg, bus.W_Addr, bus.W_Data);
endmodule

// File: doc/gpr_file_p.md
# gpr_file_p

Parametrised general-purpose register file for the RICPU datapath, successor to the fixed 32x32 GPR bank. Width, depth and zero-register behaviour are parameters. Adds same-cycle write-to-read bypass. Clearing is done by a sequential clear engine, one entry per cycle, rather than a flash clear, so the array can map to distributed/block RAM; the engine can also be re-triggered at runtime.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- ZERO_REG, 1, 1: entry 0 reads 0 and ignores writes; 0: entry 0 is an ordinary register
- BYPASS, 1, 1: a write in cycle N is visible on a matching read port in cycle N; 0: visible from cycle N+1

Ports:
- clk  in  1  clock; all state changes on rising edge
- rst  in  1  synchronous, active-low reset
- R_Addr_A  in  ADDR_W  read port A address
- R_Addr_B  in  ADDR_W  read port B address
- R_Data_A  out  DATA_W  read port A data, combinational
- R_Data_B  out  DATA_W  read port B data, combinational
- Write_Reg  in  1  write enable
- W_Addr  in  ADDR_W  write address
- W_Data  in  DATA_W  write data
- Clr_Req  in  1  request sequential clear; sampled only in IDLE
- Busy  out  1  clear in progress; writes are dropped
- Wr_Drop  out  1  registered one-cycle pulse: a write was refused because Busy was high

## Operation
- FSM states: CLEAR, IDLE. A clear counter clr_cnt is ADDR_W bits wide.
- rst low at an edge: state <= CLEAR, clr_cnt <= 0, Wr_Drop <= 0. Array contents are not touched by reset itself.
- CLEAR: each edge writes 0 to entry clr_cnt, then clr_cnt increments.
  - The edge where clr_cnt == DEPTH-1 writes the last entry and moves to IDLE. clr_cnt wraps to 0.
  - CLEAR lasts exactly DEPTH cycles after rst is released.
- IDLE:
  - Clr_Req=1 at an edge: state <= CLEAR, clr_cnt <= 0. Any write presented at that same edge is still performed, because it precedes the clear.
  - Otherwise, if Write_Reg=1 and the target is not protected entry 0, REG[W_Addr] <= W_Data.
- Busy = (state == CLEAR). It is a registered state decode.
- Writes while Busy: dropped. Wr_Drop = 1 on the following cycle for each edge with Write_Reg=1 and Busy=1.
- Writes to entry 0 with ZERO_REG=1: silently ignored, with no Wr_Drop.
- Read path, evaluated per port with X = A or B, in priority order:
  1. Busy=1 -> 0.
  2. ZERO_REG=1 and R_Addr_X == 0 -> 0.
  3. BYPASS=1, Write_Reg=1, W_Addr == R_Addr_X -> W_Data.
  4. Otherwise -> REG[R_Addr_X].
- Both ports are independent and may address the same entry.

## Timing
- Reset values: Busy=1, Wr_Drop=0, R_Data_A=R_Data_B=0 (forced by Busy).
- Clear latency: Busy falls at the DEPTH-th rising edge after the first edge with rst=1. For defaults, Busy is high 32 cycles.
- rst low mid-CLEAR: the clear restarts from entry 0 and runs a full DEPTH cycles again.
- Clr_Req while Busy: ignored; it does not extend or restart the clear.
- Write latency: data is stored at the edge. With BYPASS=0, a read of the same address returns new data one cycle later. With BYPASS=1, it returns new data in the same cycle.
- Write presented in the same cycle Busy falls, i.e. state is already IDLE: accepted.
- Wr_Drop: one-cycle latency, never asserted in IDLE except for the cycle following a dropped write.

## Test plan
- Reset/clear: hold rst=0 for 3 cycles, release. Busy must stay 1 for exactly 32 cycles, reads must be 0, and after Busy=0 all 32 entries must read 0.
- Write/read: write 0xDEADBEEF to r5 and 0x12345678 to r31. Next cycle, A=r5 and B=r31 must return those values. Write 0xFFFFFFFF to r0 -> r0 reads 0 and Wr_Drop=0.
- Bypass: BYPASS=1, write 0xA5A5A5A5 to r7 with R_Addr_A=7 in the same cycle -> R_Data_A=0xA5A5A5A5 that cycle. Repeat with BYPASS=0 -> old value that cycle, new value the next.
- Runtime clear: fill r1..r31 with their own index, pulse Clr_Req together with a write of 0x55 to r3. Busy=1 for 32 cycles, a write during Busy gives Wr_Drop=1 one cycle later, and all entries read 0 afterwards.
- Reset mid-clear: drop rst for 1 cycle at clr_cnt=10 -> Busy stays 1 for a full 32 cycles after release.
- Parameter sweep: DATA_W=16, ADDR_W=3, ZERO_REG=0 -> Busy lasts 8 cycles, and r0 stores and returns 0xBEEF.
